// File: rtl/am2940_dma_sequencer.sv
// Master-side sequencer for one Am2940 address-generator slice: programs control, address and count,
// paces words with a req/ack handshake, watches DONE and reads the counters back at the end.
// Latency: 3 load cycles + 3 cycles per word (RUN/STEP/CHK) + 2 (readback, complete); outputs registered.
// Backpressure: xfer_req stays high in RUN until xfer_ack; start outside IDLE is ignored.
//
// Ports: clk/rst_n (async active-low); start + cfg_ctrl/cfg_addr/cfg_count request; abort;
//   instr/data_out/data_oe/data_in/done_in to the slice; xfer_req/xfer_ack memory handshake;
//   busy/cmplt/err/aborted status; cur_addr/rem_count/xfer_cnt observed values.
module am2940_dma_sequencer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [2:0]   cfg_ctrl,
  input  logic [W-1:0] cfg_addr,
  input  logic [W-1:0] cfg_count,
  input  logic         abort,
  output logic [2:0]   instr,
  output logic [W-1:0] data_out,
  output logic         data_oe,
  input  logic [W-1:0] data_in,
  input  logic         done_in,
  output logic         xfer_req,
  input  logic         xfer_ack,
  output logic         busy,
  output logic         cmplt,
  output logic         err,
  output logic         aborted,
  output logic [W-1:0] cur_addr,
  output logic [W-1:0] rem_count,
  output logic [W-1:0] xfer_cnt
);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_CR, S_LD_AD, S_LD_WC, S_RUN, S_STEP, S_CHK, S_RB_WC, S_FIN
  } state_t;

  localparam logic [2:0] I_WR_CR = 3'b000;
  localparam logic [2:0] I_RD_WC = 3'b010;
  localparam logic [2:0] I_RD_AC = 3'b011;
  localparam logic [2:0] I_LD_AD = 3'b101;
  localparam logic [2:0] I_LD_WC = 3'b110;
  localparam logic [2:0] I_EN_CT = 3'b111;

  state_t         state_q, state_d;
  logic [2:0]     instr_q, instr_d;
  logic [W-1:0]   data_out_q, data_out_d;
  logic           data_oe_q, data_oe_d;
  logic           xfer_req_q, xfer_req_d;
  logic           cmplt_q, cmplt_d;
  logic           err_q, err_d;
  logic           aborted_q, aborted_d;
  logic [W-1:0]   cur_addr_q, cur_addr_d;
  logic [W-1:0]   rem_count_q, rem_count_d;
  logic [W-1:0]   xfer_cnt_q, xfer_cnt_d;
  logic [2:0]     ctrl_q, ctrl_d;
  logic [W-1:0]   addr_q, addr_d;
  logic [W-1:0]   count_q, count_d;

  // Next-state and bookkeeping, keyed on the current state.
  always_comb begin
    state_d     = state_q;
    err_d       = 1'b0;
    aborted_d   = aborted_q;
    cur_addr_d  = cur_addr_q;
    rem_count_d = rem_count_q;
    xfer_cnt_d  = xfer_cnt_q;
    ctrl_d      = ctrl_q;
    addr_d      = addr_q;
    count_d     = count_q;
    case (state_q)
      S_IDLE: begin
        cur_addr_d = data_in;
        if (start) begin
          // Zero count with the word counter in stop-on-zero mode would never terminate.
          if (cfg_count == '0 && cfg_ctrl[1:0] == 2'b00) begin
            err_d = 1'b1;
          end else begin
            ctrl_d     = cfg_ctrl;
            addr_d     = cfg_addr;
            count_d    = cfg_count;
            xfer_cnt_d = '0;
            aborted_d  = 1'b0;
            state_d    = S_WR_CR;
          end
        end
      end
      S_WR_CR, S_LD_AD, S_LD_WC: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = S_RB_WC;
        end else begin
          state_d = (state_q == S_WR_CR) ? S_LD_AD :
                    (state_q == S_LD_AD) ? S_LD_WC : S_RUN;
        end
      end
      S_RUN: begin
        cur_addr_d = data_in;
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = S_RB_WC;
        end else if (xfer_ack) begin
          state_d = S_STEP;
        end
      end
      S_STEP: begin
        // A step in flight always completes; abort is looked at again in CHK.
        xfer_cnt_d = xfer_cnt_q + 1'b1;
        state_d    = S_CHK;
      end
      S_CHK: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = S_RB_WC;
        end else if (done_in) begin
          state_d = S_RB_WC;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RB_WC: begin
        rem_count_d = data_in;
        state_d     = S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered values line up with state_q.
  always_comb begin
    instr_d    = I_RD_AC;
    data_oe_d  = 1'b0;
    data_out_d = data_out_q;
    xfer_req_d = 1'b0;
    cmplt_d    = 1'b0;
    case (state_d)
      S_WR_CR: begin
        instr_d    = I_WR_CR;
        data_oe_d  = 1'b1;
        data_out_d = {{(W-3){1'b0}}, ctrl_d};
      end
      S_LD_AD: begin
        instr_d    = I_LD_AD;
        data_oe_d  = 1'b1;
        data_out_d = addr_d;
      end
      S_LD_WC: begin
        instr_d    = I_LD_WC;
        data_oe_d  = 1'b1;
        data_out_d = count_d;
      end
      S_RUN:   xfer_req_d = 1'b1;
      S_STEP:  instr_d = I_EN_CT;
      S_RB_WC: instr_d = I_RD_WC;
      S_FIN:   cmplt_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      instr_q     <= I_RD_AC;
      data_out_q  <= '0;
      data_oe_q   <= 1'b0;
      xfer_req_q  <= 1'b0;
      cmplt_q     <= 1'b0;
      err_q       <= 1'b0;
      aborted_q   <= 1'b0;
      cur_addr_q  <= '0;
      rem_count_q <= '0;
      xfer_cnt_q  <= '0;
      ctrl_q      <= '0;
      addr_q      <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      data_out_q  <= data_out_d;
      data_oe_q   <= data_oe_d;
      xfer_req_q  <= xfer_req_d;
      cmplt_q     <= cmplt_d;
      err_q       <= err_d;
      aborted_q   <= aborted_d;
      cur_addr_q  <= cur_addr_d;
      rem_count_q <= rem_count_d;
      xfer_cnt_q  <= xfer_cnt_d;
      ctrl_q      <= ctrl_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
    end
  end

  assign instr     = instr_q;
  assign data_out  = data_out_q;
  assign data_oe   = data_oe_q;
  assign xfer_req  = xfer_req_q;
  assign busy      = (state_q != S_IDLE);
  assign cmplt     = cmplt_q;
  assign err       = err_q;
  assign aborted   = aborted_q;
  assign cur_addr  = cur_addr_q;
  assign rem_count = rem_count_q;
  assign xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_am2940_dma_sequencer.sv
// Directed bench for am2940_dma_sequencer with a behavioural Am2940 slice and memory responder.
// Latency: checks start-to-cmplt cycle counts against hand-computed values.
// Backpressure: memory ack is delayed by a programmable number of RUN cycles.
module tb_am2940_dma_sequencer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [2:0]   cfg_ctrl;
  logic [W-1:0] cfg_addr;
  logic [W-1:0] cfg_count;
  logic         abort;
  logic [2:0]   instr;
  logic [W-1:0] data_out;
  logic         data_oe;
  logic [W-1:0] data_in;
  logic         done_in;
  logic         xfer_req;
  logic         xfer_ack;
  logic         busy, cmplt, err, aborted;
  logic [W-1:0] cur_addr, rem_count, xfer_cnt;

  int n_checks = 0;
  int n_errors = 0;

  am2940_dma_sequencer #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_ctrl(cfg_ctrl), .cfg_addr(cfg_addr),
    .cfg_count(cfg_count), .abort(abort), .instr(instr), .data_out(data_out), .data_oe(data_oe),
    .data_in(data_in), .done_in(done_in), .xfer_req(xfer_req), .xfer_ack(xfer_ack), .busy(busy),
    .cmplt(cmplt), .err(err), .aborted(aborted), .cur_addr(cur_addr), .rem_count(rem_count),
    .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  // Slice model: control/address/word-count registers, counters step on 111.
  logic [2:0]   mdl_ctrl = '0;
  logic [W-1:0] mdl_addr = '0;
  logic [W-1:0] mdl_wc   = '0;
  always @(posedge clk) begin
    case (instr)
      3'b000: mdl_ctrl <= data_out[2:0];
      3'b101: mdl_addr <= data_out;
      3'b110: mdl_wc   <= data_out;
      3'b111: begin
        mdl_wc   <= mdl_wc - 1'b1;
        mdl_addr <= mdl_ctrl[2] ? mdl_addr - 1'b1 : mdl_addr + 1'b1;
      end
      default: ;
    endcase
  end
  always_comb begin
    data_in = (instr == 3'b010) ? mdl_wc : mdl_addr;
    done_in = (mdl_wc == '0);
  end

  // Memory responder: ack once xfer_req has been high for ack_delay cycles.
  int ack_delay = 0;
  int req_age   = 0;
  always @(negedge clk) begin
    xfer_ack = xfer_req && (req_age >= ack_delay);
    req_age  = xfer_req ? req_age + 1 : 0;
  end

  // Event monitor.
  int          n_steps = 0, n_cmplt = 0, n_err = 0, n_req = 0;
  logic [63:0] instr_hist = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (instr == 3'b111) n_steps = n_steps + 1;
      if (cmplt)           n_cmplt = n_cmplt + 1;
      if (err)             n_err   = n_err + 1;
      if (xfer_req)        n_req   = n_req + 1;
      instr_hist = {instr_hist[60:0], instr};
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_counts();
    n_steps = 0; n_cmplt = 0; n_err = 0; n_req = 0;
  endtask

  // Returns at the negedge of the first cycle after start is sampled (cycle 1).
  task automatic start_xfer(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] n);
    @(negedge clk);
    cfg_ctrl = c; cfg_addr = a; cfg_count = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_cmplt(input int c0, output int cyc);
    cyc = c0;
    while (!cmplt && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    if (!cmplt) check("cmplt_timeout", 64'd0, 64'd1);
    #1;
  endtask

  int          cyc;
  logic [41:0] exp_seq;
  int          guard;

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    cfg_ctrl = '0; cfg_addr = '0; cfg_count = '0; xfer_ack = 1'b0;

    // Reset state.
    #12;
    check("rst_instr", instr, 3'b011);
    check("rst_flags", {busy, cmplt, err, aborted, xfer_req, data_oe}, 6'b0);
    check("rst_regs", {data_out, cur_addr, rem_count, xfer_cnt}, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_instr", instr, 3'b011);
    check("idle_flags", {busy, cmplt, err, aborted, xfer_req, data_oe}, 6'b0);

    // Normal 3-word transfer, ack immediate.
    clear_counts(); ack_delay = 0;
    start_xfer(3'b000, 8'h40, 8'd3);
    check("wr_cr", {instr, data_out, data_oe, busy}, {3'b000, 8'h00, 1'b1, 1'b1});
    @(negedge clk);
    check("ld_ad", {instr, data_out, data_oe}, {3'b101, 8'h40, 1'b1});
    @(negedge clk);
    check("ld_wc", {instr, data_out, data_oe}, {3'b110, 8'h03, 1'b1});
    wait_cmplt(3, cyc);
    exp_seq = {3'b000, 3'b101, 3'b110, 3'b011, 3'b111, 3'b011, 3'b011, 3'b111, 3'b011,
               3'b011, 3'b111, 3'b011, 3'b010, 3'b011};
    check("norm_seq", instr_hist[41:0], exp_seq);
    check("norm_latency", cyc, 14);
    check("norm_result", {xfer_cnt, rem_count, 7'b0, aborted}, {8'd3, 8'd0, 8'd0});
    check("norm_data_hold", {data_out, data_oe}, {8'h03, 1'b0});
    repeat (2) @(negedge clk);
    check("norm_end", {busy, cur_addr}, {1'b0, 8'h43});
    check("norm_pulses", {n_cmplt[7:0], n_steps[7:0]}, {8'd1, 8'd3});

    // Throttled handshake with a start pulse while busy.
    clear_counts(); ack_delay = 4;
    start_xfer(3'b001, 8'h10, 8'd2);
    repeat (6) @(negedge clk);
    cfg_count = 8'd0; cfg_ctrl = 3'b000; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_cmplt(8, cyc);
    check("thr_latency", cyc, 19);
    check("thr_steps", n_steps, 2);
    check("thr_req_cycles", n_req, 10);
    check("thr_cnt", xfer_cnt, 8'd2);
    @(negedge clk);
    check("thr_no_err_cmplt_once", {n_err[7:0], n_cmplt[7:0]}, {8'd0, 8'd1});

    // Abort in RUN after 4 words, decrementing addresses.
    clear_counts(); ack_delay = 0;
    start_xfer(3'b100, 8'h80, 8'd10);
    guard = 0;
    while (!(xfer_req && xfer_cnt == 8'd4) && guard < 200) begin
      @(negedge clk); guard++;
    end
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    wait_cmplt(0, cyc);
    check("abt_steps", n_steps, 4);
    check("abt_result", {xfer_cnt, rem_count, 7'b0, aborted}, {8'd4, 8'd6, 8'd1});
    repeat (3) @(negedge clk);
    check("abt_after", {n_cmplt[7:0], cur_addr, 7'b0, aborted}, {8'd1, 8'h7C, 8'd1});

    // Rejected request.
    clear_counts();
    @(negedge clk);
    cfg_ctrl = 3'b000; cfg_count = 8'd0; cfg_addr = 8'h55; start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("rej_pulse", {err, busy, instr}, {1'b1, 1'b0, 3'b011});
    @(negedge clk);
    check("rej_after", {err, busy, instr, aborted}, {1'b0, 1'b0, 3'b011, 1'b1});

    // Async reset during STEP, then a clean transfer.
    clear_counts();
    start_xfer(3'b000, 8'h20, 8'd5);
    guard = 0;
    while (instr != 3'b111 && guard < 200) begin
      @(negedge clk); guard++;
    end
    #2 rst_n = 1'b0;
    #1;
    check("arst_instr", instr, 3'b011);
    check("arst_flags", {busy, xfer_req, data_oe, cmplt, aborted}, 5'b0);
    check("arst_regs", {xfer_cnt, data_out, rem_count}, 24'h0);
    @(negedge clk); rst_n = 1'b1;
    clear_counts();
    start_xfer(3'b000, 8'h30, 8'd2);
    wait_cmplt(1, cyc);
    check("post_latency", cyc, 11);
    check("post_result", {xfer_cnt, rem_count, 7'b0, aborted}, {8'd2, 8'd0, 8'd0});
    check("post_steps", n_steps, 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
